sfp_seq: RTL and testbench

- Control sequencer for one core's sfp_row datapath.
- Sequences three phases of the softmax normalisation:
  - Accumulate: reads psum rows from the psum memory and asserts acc.
  - Sync: two-core handshake with the peer core.
  - Divide: asserts div and fifo_ext_rd row by row, and writes normalised rows to the output memory.
- Sits between the core controller, the psum/output SRAMs, sfp_row and the peer core's sfp_seq.

---
 rtl/sfp_defs.sv | 27 ++
 rtl/sfp_ctrl_pipe.sv | 60 ++++++
 rtl/sfp_seq.sv | 167 ++++++++++++++++
 tb/tb_sfp_seq.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sfp_defs.sv
// Shared definitions for the softmax row sequencer and sfp_row: state encodings,
// datapath latencies and drain lengths.
package sfp_defs;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ACC       = 3'd1;
  localparam logic [2:0] ST_ACC_DRAIN = 3'd2;
  localparam logic [2:0] ST_SYNC      = 3'd3;
  localparam logic [2:0] ST_DIV       = 3'd4;
  localparam logic [2:0] ST_DIV_DRAIN = 3'd5;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    ACC       = ST_ACC,
    ACC_DRAIN = ST_ACC_DRAIN,
    SYNC      = ST_SYNC,
    DIV       = ST_DIV,
    DIV_DRAIN = ST_DIV_DRAIN
  } state_t;

  localparam int SRAM_RD_LAT   = 1;
  localparam int SFP_DIV_LAT   = 1;
  localparam int ACC_DRAIN_CYC = 2;
  // The divide phase drains until the last read has crossed both the SRAM and the divider.
  localparam int DIV_DRAIN_CYC = SRAM_RD_LAT + SFP_DIV_LAT;

endpackage

// File: rtl/sfp_ctrl_pipe.sv
// Delay line that lines up acc/div/fifo_ext_rd with SRAM read data and the
// omem write strobe and row address with the divider output.
module sfp_ctrl_pipe
  import sfp_defs::*;
#(
  parameter int addr_bw = 4,
  parameter int rd_lat  = SRAM_RD_LAT,
  parameter int div_lat = SFP_DIV_LAT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               acc_req,
  input  logic               div_req,
  input  logic [addr_bw-1:0] row_in,
  output logic               acc,
  output logic               div,
  output logic               fifo_ext_rd,
  output logic               omem_wr,
  output logic [addr_bw-1:0] omem_addr
);

  logic [rd_lat-1:0]  acc_sr;
  logic [rd_lat-1:0]  div_sr;
  logic [addr_bw-1:0] row_sr [rd_lat];
  logic [div_lat-1:0] wr_sr;
  logic [addr_bw-1:0] waddr_sr [div_lat];

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_sr <= '0;
      div_sr <= '0;
      wr_sr  <= '0;
      for (int i = 0; i < rd_lat; i++) row_sr[i] <= '0;
      for (int i = 0; i < div_lat; i++) waddr_sr[i] <= '0;
    end else begin
      acc_sr[0]   <= acc_req;
      div_sr[0]   <= div_req;
      row_sr[0]   <= row_in;
      for (int i = 1; i < rd_lat; i++) begin
        acc_sr[i] <= acc_sr[i-1];
        div_sr[i] <= div_sr[i-1];
        row_sr[i] <= row_sr[i-1];
      end
      // The write stage follows the divide strobe, carrying the row index it divided.
      wr_sr[0]    <= div_sr[rd_lat-1];
      waddr_sr[0] <= row_sr[rd_lat-1];
      for (int i = 1; i < div_lat; i++) begin
        wr_sr[i]    <= wr_sr[i-1];
        waddr_sr[i] <= waddr_sr[i-1];
      end
    end
  end

  assign acc         = acc_sr[rd_lat-1];
  assign div         = div_sr[rd_lat-1];
  assign fifo_ext_rd = div_sr[rd_lat-1];
  assign omem_wr     = wr_sr[div_lat-1];
  assign omem_addr   = waddr_sr[div_lat-1];

endmodule

// File: rtl/sfp_seq.sv
// Softmax sequencer: accumulate, two-core sum sync, divide. Build with
// SFP_SEQ_PERF_EN to add the perf_cycles pass-length counter.
module sfp_seq
  import sfp_defs::*;
#(
  parameter int row_num = 8,
  parameter int addr_bw = 4,
  parameter int cnt_bw  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pmem_rd,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               acc,
  output logic               div,
  output logic               fifo_ext_rd,
  output logic               sum_rdy_out,
  input  logic               peer_sum_rdy,
  output logic               omem_wr,
  output logic [addr_bw-1:0] omem_addr,
  output state_t             state
`ifdef SFP_SEQ_PERF_EN
  ,
  output logic [cnt_bw-1:0]  perf_cycles
`endif
);

  if (row_num < 1 || row_num > 15 || row_num > 2**addr_bw) begin : g_bad_row_num
    $error("sfp_seq: row_num must be 1..15 and fit in addr_bw bits");
  end
  if (cnt_bw < 1) begin : g_bad_cnt_bw
    $error("sfp_seq: cnt_bw must be at least 1");
  end

  localparam logic [addr_bw-1:0] LAST_ROW       = addr_bw'(row_num - 1);
  localparam logic [2:0]         ACC_DRAIN_LAST = 3'(ACC_DRAIN_CYC - 1);
  localparam logic [2:0]         DIV_DRAIN_LAST = 3'(DIV_DRAIN_CYC - 1);
  localparam logic [2:0]         DONE_AT        = 3'(DIV_DRAIN_CYC - 2);

  logic [2:0] drain;

  // Handshake: sum_rdy_out is raised one cycle after SYNC is entered and both
  // cores leave SYNC on the first edge where their registered flags overlap,
  // so the two DIV phases begin on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      pmem_rd     <= 1'b0;
      pmem_addr   <= '0;
      sum_rdy_out <= 1'b0;
      drain       <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= ACC;
            busy      <= 1'b1;
            pmem_rd   <= 1'b1;
            pmem_addr <= '0;
          end
        end
        ACC: begin
          if (pmem_addr == LAST_ROW) begin
            state     <= ACC_DRAIN;
            pmem_rd   <= 1'b0;
            pmem_addr <= '0;
            drain     <= '0;
          end else begin
            pmem_addr <= pmem_addr + 1'b1;
          end
        end
        ACC_DRAIN: begin
          if (drain == ACC_DRAIN_LAST) begin
            state <= SYNC;
            drain <= '0;
          end else begin
            drain <= drain + 3'd1;
          end
        end
        SYNC: begin
          if (sum_rdy_out && peer_sum_rdy) begin
            state       <= DIV;
            sum_rdy_out <= 1'b0;
            pmem_rd     <= 1'b1;
            pmem_addr   <= '0;
          end else begin
            sum_rdy_out <= 1'b1;
          end
        end
        DIV: begin
          if (pmem_addr == LAST_ROW) begin
            state     <= DIV_DRAIN;
            pmem_rd   <= 1'b0;
            pmem_addr <= '0;
            drain     <= '0;
          end else begin
            pmem_addr <= pmem_addr + 1'b1;
          end
        end
        DIV_DRAIN: begin
          // done lands in the final drain cycle, together with the last omem write.
          if (drain == DIV_DRAIN_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            drain <= '0;
          end else begin
            drain <= drain + 3'd1;
            done  <= (drain == DONE_AT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic acc_req;
  logic div_req;

  assign acc_req = pmem_rd && (state == ACC);
  assign div_req = pmem_rd && (state == DIV);

  sfp_ctrl_pipe #(
    .addr_bw (addr_bw),
    .rd_lat  (SRAM_RD_LAT),
    .div_lat (SFP_DIV_LAT)
  ) u_pipe (
    .clk         (clk),
    .reset       (reset),
    .acc_req     (acc_req),
    .div_req     (div_req),
    .row_in      (pmem_addr),
    .acc         (acc),
    .div         (div),
    .fifo_ext_rd (fifo_ext_rd),
    .omem_wr     (omem_wr),
    .omem_addr   (omem_addr)
  );

`ifdef SFP_SEQ_PERF_EN
  logic [cnt_bw-1:0] cnt;
  logic [cnt_bw-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (cnt != '1) cnt_nxt = cnt + 1'b1;
  end

  // The done cycle is itself busy, so the latched value includes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      perf_cycles <= '0;
    end else begin
      if (state == IDLE && start) cnt <= '0;
      else if (busy) cnt <= cnt_nxt;
      if (done) perf_cycles <= cnt_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_sfp_seq.sv
// Directed bench for sfp_seq with an omem-address scoreboard and per-pass
// timing checks against cycle offsets from start and from the sync overlap.
module tb_sfp_seq;
  import sfp_defs::*;

`ifdef SFP_SEQ_PERF_EN
  localparam int RN = 4;
  localparam int CB = 4;
`else
  localparam int RN = 8;
  localparam int CB = 16;
`endif
  localparam int AW = 4;

  logic          clk;
  logic          reset;
  logic          start;
  logic          busy;
  logic          done;
  logic          pmem_rd;
  logic [AW-1:0] pmem_addr;
  logic          acc;
  logic          div;
  logic          fifo_ext_rd;
  logic          sum_rdy_out;
  logic          peer_sum_rdy;
  logic          omem_wr;
  logic [AW-1:0] omem_addr;
  state_t        dut_state;
`ifdef SFP_SEQ_PERF_EN
  logic [CB-1:0] perf_cycles;
`endif

  sfp_seq #(.row_num(RN), .addr_bw(AW), .cnt_bw(CB)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .pmem_rd      (pmem_rd),
    .pmem_addr    (pmem_addr),
    .acc          (acc),
    .div          (div),
    .fifo_ext_rd  (fifo_ext_rd),
    .sum_rdy_out  (sum_rdy_out),
    .peer_sum_rdy (peer_sum_rdy),
    .omem_wr      (omem_wr),
    .omem_addr    (omem_addr),
    .state        (dut_state)
`ifdef SFP_SEQ_PERF_EN
    ,
    .perf_cycles  (perf_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard and logs ----------------
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;
  logic [AW-1:0] exp_q[$];
  int acc_q[$], div_q[$], omem_q[$], done_q[$], sum_q[$], prd_q[$], pad_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (acc) acc_q.push_back(cyc);
      if (div) div_q.push_back(cyc);
      if (done) done_q.push_back(cyc);
      if (sum_rdy_out) sum_q.push_back(cyc);
      if (pmem_rd) begin
        prd_q.push_back(cyc);
        pad_q.push_back(int'(pmem_addr));
      end
      if (acc || div || fifo_ext_rd) begin
        chk("acc_div_exclusive", 32'(acc & div), 32'd0);
        chk("fifo_ext_rd_with_div", 32'(fifo_ext_rd), 32'(div));
      end
      if (omem_wr) begin
        omem_q.push_back(cyc);
        chk("omem_write_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("omem_addr", 32'(omem_addr), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    acc_q.delete(); div_q.delete(); omem_q.delete(); done_q.delete();
    sum_q.delete(); prd_q.delete(); pad_q.delete();
  endtask

  task automatic start_now(output int s);
    start = 1'b1;
    s = cyc;
    for (int i = 0; i < RN; i++) exp_q.push_back(AW'(i));
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int d);
    bit found = 1'b0;
    d = 0;
    for (int k = 0; k < 400 && !found; k++) begin
      step();
      if (done) begin
        found = 1'b1;
        d = cyc;
      end
    end
    chk("done_within_budget", 32'(found), 32'd1);
  endtask

  task automatic wait_sum(output int t);
    bit found = 1'b0;
    t = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      step();
      if (sum_rdy_out) begin
        found = 1'b1;
        t = cyc;
      end
    end
    chk("sum_rdy_within_budget", 32'(found), 32'd1);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_pmem_rd"}, 32'(pmem_rd), 32'd0);
    chk({tag, "_pmem_addr"}, 32'(pmem_addr), 32'd0);
    chk({tag, "_acc"}, 32'(acc), 32'd0);
    chk({tag, "_div"}, 32'(div), 32'd0);
    chk({tag, "_fifo_ext_rd"}, 32'(fifo_ext_rd), 32'd0);
    chk({tag, "_sum_rdy_out"}, 32'(sum_rdy_out), 32'd0);
    chk({tag, "_omem_wr"}, 32'(omem_wr), 32'd0);
    chk({tag, "_omem_addr"}, 32'(omem_addr), 32'd0);
    chk({tag, "_state"}, 32'(dut_state), 32'(ST_IDLE));
`ifdef SFP_SEQ_PERF_EN
    chk({tag, "_perf_cycles"}, 32'(perf_cycles), 32'd0);
`endif
  endtask

  task automatic chk_perf(input int s, input int d);
`ifdef SFP_SEQ_PERF_EN
    int e = d - s;
    if (e > 2**CB - 1) e = 2**CB - 1;
    chk("perf_cycles", 32'(perf_cycles), 32'(e));
`endif
  endtask

  // s: start cycle, o: cycle in which sum_rdy_out and peer_sum_rdy first overlap
  task automatic check_pass(input int s, input int o);
    chk("acc_count", 32'(acc_q.size()), 32'(RN));
    chk("div_count", 32'(div_q.size()), 32'(RN));
    chk("omem_count", 32'(omem_q.size()), 32'(RN));
    chk("pmem_rd_count", 32'(prd_q.size()), 32'(2 * RN));
    chk("done_count", 32'(done_q.size()), 32'd1);
    chk("sum_rdy_cycles", 32'(sum_q.size()), 32'(o - (s + RN + 4) + 1));
    if (sum_q.size() > 0) chk("sum_rdy_rise", 32'(sum_q[0]), 32'(s + RN + 4));
    if (done_q.size() > 0) chk("done_cycle", 32'(done_q[0]), 32'(o + RN + 2));
    for (int i = 0; i < RN; i++) begin
      if (i < acc_q.size()) chk("acc_cycle", 32'(acc_q[i]), 32'(s + 2 + i));
      if (i < div_q.size()) chk("div_cycle", 32'(div_q[i]), 32'(o + 2 + i));
      if (i < omem_q.size()) chk("omem_cycle", 32'(omem_q[i]), 32'(o + 3 + i));
      if (i < prd_q.size()) begin
        chk("acc_rd_cycle", 32'(prd_q[i]), 32'(s + 1 + i));
        chk("acc_rd_addr", 32'(pad_q[i]), 32'(i));
      end
      if (RN + i < prd_q.size()) begin
        chk("div_rd_cycle", 32'(prd_q[RN + i]), 32'(o + 1 + i));
        chk("div_rd_addr", 32'(pad_q[RN + i]), 32'(i));
      end
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s, s2, d, d2, t, o;
    reset = 1'b1;
    start = 1'b0;
    peer_sum_rdy = 1'b0;
    repeat (3) step();
    chk_idle("in_reset");
    reset = 1'b0;
    step();
    chk_idle("after_reset");
    mon_en = 1'b1;

    // single pass, peer ready throughout
    peer_sum_rdy = 1'b1;
    step();
    start_now(s);
    chk("busy_after_start", 32'(busy), 32'd1);
    wait_done(d);
    check_pass(s, s + RN + 4);
    step();
    chk("gap_busy", 32'(busy), 32'd0);
    chk("gap_state", 32'(dut_state), 32'(ST_IDLE));
    chk_perf(s, d);
    clear_logs();

    // back-to-back: start in the first IDLE cycle after done
    start_now(s2);
    wait_done(d2);
    check_pass(s2, s2 + RN + 4);
    chk("b2b_done_spacing", 32'(d2 - d), 32'(2 * RN + 7));
    step();
    chk_perf(s2, d2);
    clear_logs();

    // peer arrives 20 cycles after the local sums are ready
    peer_sum_rdy = 1'b0;
    step();
    start_now(s);
    wait_sum(t);
    chk("late_sum_rise", 32'(t), 32'(s + RN + 4));
    repeat (20) step();
    chk("late_hold_state", 32'(dut_state), 32'(ST_SYNC));
    peer_sum_rdy = 1'b1;
    o = cyc;
    wait_done(d);
    check_pass(s, o);
    step();
    chk_perf(s, d);
    clear_logs();

    // start pulses during ACC and DIV are ignored
    step();
    start_now(s);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    o = s + RN + 4;
    while (cyc < o + 3) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(d);
    check_pass(s, o);
    step();
    chk_perf(s, d);
    clear_logs();

    // reset sampled at the end of the cycle carrying the 3rd div
    step();
    start_now(s);
    for (int k = 0; k < 100 && div_q.size() < 3; k++) step();
    chk("third_div_seen", 32'(div_q.size()), 32'd3);
    reset = 1'b1;
    step();
    chk_idle("abort");
    reset = 1'b0;
    repeat (3) step();
    chk("abort_omem_writes", 32'(omem_q.size()), 32'd2);
    chk("abort_pending_rows", 32'(exp_q.size()), 32'(RN - 2));
    chk("abort_div_count", 32'(div_q.size()), 32'd3);
    chk("abort_pmem_reads", 32'(prd_q.size()), 32'(RN + ((RN < 4) ? RN : 4)));
    chk("abort_done_count", 32'(done_q.size()), 32'd0);
    exp_q.delete();
    clear_logs();

    // full pass after the abort
    start_now(s);
    wait_done(d);
    check_pass(s, s + RN + 4);
    step();
    chk_perf(s, d);
    chk("final_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
